rib_regbank: RTL

Parametrised RIB-bus register bank for the ADC/UDP DAQ path, the successor to the single-cycle RIB register block. It holds UDP and ADC configuration, per-channel baseline, noise, calibration and test arrays, and system mode/status. Over the existing interface it adds registered reads with an acknowledge, a coherent ADC snapshot with a lock, overrun counting, and sticky access-error reporting. It sits between the RIB master (CPU) and the ADC front-end and UDP transmitter.

---
 rtl/rib_regbank.sv | 367 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rib_regbank.sv
// rib_regbank: RIB-bus register bank for the ADC/UDP DAQ path.
// Holds the UDP and ADC configuration, four per-channel arrays, system mode and status, and
// a coherent ADC snapshot with a read lock. Reads are registered and every strobe is
// acknowledged one cycle later.
//
// Ports:
//   rib_clk, rib_rst_n             clock, async active-low reset
//   rib_addr/rib_data_i            byte address (only [15:0] decoded), write data
//   rib_we/rib_re                  one-cycle write/read strobes
//   rib_data_o/rib_ack             registered read data, one-cycle acknowledge
//   fee_mode, udp_tx_req           front-end mode and UDP request, used for the status read
//   adc_value/adc_valid            live sample set and its strobe
//   cfg_*                          UDP/ADC configuration outputs
//   sys_status                     raw SYS_STATUS register
//   baseline_rib_data, adc_noise,
//   cal_adc_value, adc_test        flattened per-channel arrays (channel i at [i*DW +: DW])
//   data_accepted_rib              pulses with the ack of the final-channel snapshot read
module rib_regbank #(
  parameter int unsigned DATAWIDTH  = 16,
  parameter int unsigned ADC_CHANEL = 20,
  parameter int unsigned CH_SHIFT   = 3
) (
  input  logic                            rib_clk,
  input  logic                            rib_rst_n,
  input  logic [31:0]                     rib_addr,
  input  logic [31:0]                     rib_data_i,
  input  logic                            rib_we,
  input  logic                            rib_re,
  output logic [31:0]                     rib_data_o,
  output logic                            rib_ack,
  input  logic [4:0]                      fee_mode,
  input  logic                            udp_tx_req,
  input  logic [ADC_CHANEL*DATAWIDTH-1:0] adc_value,
  input  logic                            adc_valid,
  output logic [15:0]                     cfg_tx_data_num,
  output logic                            cfg_udp_tx_enable,
  output logic                            cfg_fifo_wr_en,
  output logic [31:0]                     cfg_board_ip,
  output logic [31:0]                     cfg_des_ip,
  output logic [15:0]                     cfg_board_port,
  output logic [15:0]                     cfg_des_port,
  output logic [3:0]                      cfg_adc_width,
  output logic [5:0]                      cfg_datawidth,
  output logic [21:0]                     cfg_num_channels,
  output logic [4:0]                      cfg_fee_mode,
  output logic [4:0]                      sys_status,
  output logic [ADC_CHANEL*DATAWIDTH-1:0] baseline_rib_data,
  output logic [ADC_CHANEL*DATAWIDTH-1:0] adc_noise,
  output logic [ADC_CHANEL*DATAWIDTH-1:0] cal_adc_value,
  output logic [ADC_CHANEL*DATAWIDTH-1:0] adc_test,
  output logic                            data_accepted_rib
);

  localparam int unsigned IdxW = 12 - CH_SHIFT;
  localparam int unsigned ChW  = (ADC_CHANEL > 1) ? $clog2(ADC_CHANEL) : 1;

  localparam logic [15:0] AddrUdpCtrl = 16'h0010;
  localparam logic [15:0] AddrBoardIp = 16'h0014;
  localparam logic [15:0] AddrDesIp   = 16'h0018;
  localparam logic [15:0] AddrBoardPt = 16'h001C;
  localparam logic [15:0] AddrDesPt   = 16'h0020;
  localparam logic [15:0] AddrAdcCfg  = 16'h0024;
  localparam logic [15:0] AddrStatus  = 16'h0028;
  localparam logic [15:0] AddrMode    = 16'h0030;
  localparam logic [15:0] AddrOverrun = 16'h0034;
  localparam logic [15:0] AddrErr     = 16'h0038;

  localparam logic [3:0] RegSnap  = 4'h1;
  localparam logic [3:0] RegBase  = 4'h2;
  localparam logic [3:0] RegNoise = 4'h3;
  localparam logic [3:0] RegCal   = 4'h4;
  localparam logic [3:0] RegTest  = 4'h5;

  // Scalar state
  logic [15:0] tx_data_num_q, tx_data_num_d;
  logic        udp_tx_enable_q, udp_tx_enable_d;
  logic        fifo_wr_en_q, fifo_wr_en_d;
  logic [31:0] board_ip_q, board_ip_d;
  logic [31:0] des_ip_q, des_ip_d;
  logic [15:0] board_port_q, board_port_d;
  logic [15:0] des_port_q, des_port_d;
  logic [3:0]  adc_width_q, adc_width_d;
  logic [5:0]  datawidth_q, datawidth_d;
  logic [21:0] num_channels_q, num_channels_d;
  logic [4:0]  sys_status_q, sys_status_d;
  logic [4:0]  fee_mode_q, fee_mode_d;
  logic [15:0] overrun_q, overrun_d;
  logic [1:0]  err_q, err_d;
  logic        lock_q, lock_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        accepted_q, accepted_d;

  // Channel arrays
  logic [DATAWIDTH-1:0] snap_q  [ADC_CHANEL];
  logic [DATAWIDTH-1:0] base_q  [ADC_CHANEL];
  logic [DATAWIDTH-1:0] noise_q [ADC_CHANEL];
  logic [DATAWIDTH-1:0] cal_q   [ADC_CHANEL];
  logic [DATAWIDTH-1:0] test_q  [ADC_CHANEL];

  // Address decode
  logic [15:0]     addr;
  logic [3:0]      region;
  logic [IdxW-1:0] ch_idx;
  logic [31:0]     ch_idx_ext;
  logic [ChW-1:0]  ch_sel;
  logic            ch_in_range;
  logic            is_chan;
  logic            strobe;
  logic            unused_addr;

  assign addr        = rib_addr[15:0];
  assign unused_addr = ^rib_addr[31:16];
  assign region      = addr[15:12];
  assign ch_idx      = addr[11:CH_SHIFT];
  assign ch_idx_ext  = 32'(ch_idx);
  assign ch_sel      = ch_idx[ChW-1:0];
  assign ch_in_range = ch_idx_ext < ADC_CHANEL;
  assign is_chan     = (region >= RegSnap) && (region <= RegTest);
  assign strobe      = rib_we | rib_re;

  logic scalar_hit;
  logic sel_udp, sel_bip, sel_dip, sel_bpt, sel_dpt, sel_adc, sel_sts, sel_mode, sel_ovr, sel_err;

  always_comb begin
    scalar_hit = 1'b1;
    sel_udp    = 1'b0;
    sel_bip    = 1'b0;
    sel_dip    = 1'b0;
    sel_bpt    = 1'b0;
    sel_dpt    = 1'b0;
    sel_adc    = 1'b0;
    sel_sts    = 1'b0;
    sel_mode   = 1'b0;
    sel_ovr    = 1'b0;
    sel_err    = 1'b0;
    case (addr)
      AddrUdpCtrl: sel_udp    = 1'b1;
      AddrBoardIp: sel_bip    = 1'b1;
      AddrDesIp:   sel_dip    = 1'b1;
      AddrBoardPt: sel_bpt    = 1'b1;
      AddrDesPt:   sel_dpt    = 1'b1;
      AddrAdcCfg:  sel_adc    = 1'b1;
      AddrStatus:  sel_sts    = 1'b1;
      AddrMode:    sel_mode   = 1'b1;
      AddrOverrun: sel_ovr    = 1'b1;
      AddrErr:     sel_err    = 1'b1;
      default:     scalar_hit = 1'b0;
    endcase
  end

  logic unmapped, range_err, chan_ok;
  logic wr_base, wr_noise, wr_cal, wr_test;
  logic snap_rd, snap_rd_first, snap_rd_last;

  assign unmapped      = !is_chan && !scalar_hit;
  assign range_err     = is_chan && !ch_in_range;
  assign chan_ok       = is_chan && ch_in_range;
  assign wr_base       = rib_we && chan_ok && (region == RegBase);
  assign wr_noise      = rib_we && chan_ok && (region == RegNoise);
  assign wr_cal        = rib_we && chan_ok && (region == RegCal);
  assign wr_test       = rib_we && chan_ok && (region == RegTest);
  assign snap_rd       = rib_re && chan_ok && (region == RegSnap);
  assign snap_rd_first = snap_rd && (ch_idx_ext == 32'd0);
  assign snap_rd_last  = snap_rd && (ch_idx_ext == ADC_CHANEL - 1);

  // Status as seen by the CPU depends on the live front-end mode.
  logic [4:0] status_rd;
  always_comb begin
    status_rd = sys_status_q;
    case (fee_mode)
      5'd0: status_rd = 5'd0;
      5'd1: status_rd = (sys_status_q == 5'd3) ? 5'd3 : 5'd2;
      5'd2: begin
        if (sys_status_q == 5'd7) status_rd = udp_tx_req ? 5'd8 : 5'd0;
        else                      status_rd = 5'd4;
      end
      default: status_rd = sys_status_q;
    endcase
  end

  // Read mux
  logic [DATAWIDTH-1:0] chan_word;
  logic [31:0]          rd_val;
  always_comb begin
    chan_word = '0;
    case (region)
      RegSnap:  chan_word = snap_q[ch_sel];
      RegBase:  chan_word = base_q[ch_sel];
      RegNoise: chan_word = noise_q[ch_sel];
      RegCal:   chan_word = cal_q[ch_sel];
      RegTest:  chan_word = test_q[ch_sel];
      default:  chan_word = '0;
    endcase

    rd_val = '0;
    if (unmapped || range_err) begin
      rd_val = 32'hDEAD_BEEF;
    end else if (is_chan) begin
      rd_val[DATAWIDTH-1:0] = chan_word;
    end else begin
      case (1'b1)
        sel_udp:  rd_val = {14'd0, fifo_wr_en_q, udp_tx_enable_q, tx_data_num_q};
        sel_bip:  rd_val = board_ip_q;
        sel_dip:  rd_val = des_ip_q;
        sel_bpt:  rd_val = {16'd0, board_port_q};
        sel_dpt:  rd_val = {16'd0, des_port_q};
        sel_adc:  rd_val = {num_channels_q, datawidth_q, adc_width_q};
        sel_sts:  rd_val = {27'd0, status_rd};
        sel_mode: rd_val = {27'd0, fee_mode_q};
        sel_ovr:  rd_val = {16'd0, overrun_q};
        sel_err:  rd_val = {30'd0, err_q};
        default:  rd_val = '0;
      endcase
    end
  end

  // Scalar next state
  logic ovr_rd, ovr_inc;
  logic [1:0] err_set, err_clr;

  assign ovr_rd  = rib_re && sel_ovr;
  assign ovr_inc = adc_valid && lock_q;
  assign err_set = {range_err & strobe, unmapped & strobe};
  assign err_clr = (rib_we && sel_err) ? rib_data_i[1:0] : 2'b00;

  always_comb begin
    tx_data_num_d   = tx_data_num_q;
    udp_tx_enable_d = udp_tx_enable_q;
    fifo_wr_en_d    = fifo_wr_en_q;
    board_ip_d      = board_ip_q;
    des_ip_d        = des_ip_q;
    board_port_d    = board_port_q;
    des_port_d      = des_port_q;
    adc_width_d     = adc_width_q;
    datawidth_d     = datawidth_q;
    num_channels_d  = num_channels_q;
    sys_status_d    = sys_status_q;
    fee_mode_d      = fee_mode_q;
    overrun_d       = overrun_q;
    lock_d          = lock_q;

    if (rib_we) begin
      if (sel_udp) begin
        tx_data_num_d   = rib_data_i[15:0];
        udp_tx_enable_d = rib_data_i[16];
        fifo_wr_en_d    = rib_data_i[17];
      end
      if (sel_bip) board_ip_d = rib_data_i;
      if (sel_dip) des_ip_d = rib_data_i;
      if (sel_bpt) board_port_d = rib_data_i[15:0];
      if (sel_dpt) des_port_d = rib_data_i[15:0];
      if (sel_adc) begin
        num_channels_d = rib_data_i[31:10];
        datawidth_d    = rib_data_i[9:4];
        adc_width_d    = rib_data_i[3:0];
      end
      if (sel_sts)  sys_status_d = rib_data_i[4:0];
      if (sel_mode) fee_mode_d = rib_data_i[4:0];
    end

    // Clear-on-read; a coincident overrun leaves exactly one counted event behind.
    if (ovr_rd) overrun_d = '0;
    if (ovr_inc) begin
      if (ovr_rd)                        overrun_d = 16'd1;
      else if (overrun_q != 16'hFFFF)    overrun_d = overrun_q + 16'd1;
    end

    // Last-channel read wins so a single-channel bank never stays locked.
    if (snap_rd_first) lock_d = 1'b1;
    if (snap_rd_last)  lock_d = 1'b0;
  end

  assign err_d      = (err_q & ~err_clr) | err_set;
  assign rdata_d    = rib_re ? rd_val : rdata_q;
  assign ack_d      = strobe;
  assign accepted_d = snap_rd_last;

  always_ff @(posedge rib_clk or negedge rib_rst_n) begin
    if (!rib_rst_n) begin
      tx_data_num_q   <= 16'd100;
      udp_tx_enable_q <= 1'b1;
      fifo_wr_en_q    <= 1'b0;
      board_ip_q      <= 32'hC0A8_B96F;
      des_ip_q        <= 32'hC0A8_B9F3;
      board_port_q    <= 16'd1234;
      des_port_q      <= 16'd1234;
      adc_width_q     <= '0;
      datawidth_q     <= '0;
      num_channels_q  <= '0;
      sys_status_q    <= '0;
      fee_mode_q      <= 5'd1;
      overrun_q       <= '0;
      err_q           <= '0;
      lock_q          <= 1'b0;
      rdata_q         <= '0;
      ack_q           <= 1'b0;
      accepted_q      <= 1'b0;
    end else begin
      tx_data_num_q   <= tx_data_num_d;
      udp_tx_enable_q <= udp_tx_enable_d;
      fifo_wr_en_q    <= fifo_wr_en_d;
      board_ip_q      <= board_ip_d;
      des_ip_q        <= des_ip_d;
      board_port_q    <= board_port_d;
      des_port_q      <= des_port_d;
      adc_width_q     <= adc_width_d;
      datawidth_q     <= datawidth_d;
      num_channels_q  <= num_channels_d;
      sys_status_q    <= sys_status_d;
      fee_mode_q      <= fee_mode_d;
      overrun_q       <= overrun_d;
      err_q           <= err_d;
      lock_q          <= lock_d;
      rdata_q         <= rdata_d;
      ack_q           <= ack_d;
      accepted_q      <= accepted_d;
    end
  end

  always_ff @(posedge rib_clk or negedge rib_rst_n) begin
    if (!rib_rst_n) begin
      for (int i = 0; i < int'(ADC_CHANEL); i++) begin
        snap_q[i]  <= '0;
        base_q[i]  <= '0;
        noise_q[i] <= '0;
        cal_q[i]   <= '0;
        test_q[i]  <= '0;
      end
    end else begin
      // A locked snapshot stays coherent until the CPU has read it out.
      if (adc_valid && !lock_q) begin
        for (int i = 0; i < int'(ADC_CHANEL); i++) begin
          snap_q[i] <= adc_value[i*DATAWIDTH +: DATAWIDTH];
        end
      end
      if (wr_base)  base_q[ch_sel]  <= rib_data_i[DATAWIDTH-1:0];
      if (wr_noise) noise_q[ch_sel] <= rib_data_i[DATAWIDTH-1:0];
      if (wr_cal)   cal_q[ch_sel]   <= rib_data_i[DATAWIDTH-1:0];
      if (wr_test)  test_q[ch_sel]  <= rib_data_i[DATAWIDTH-1:0];
    end
  end

  for (genvar g = 0; g < int'(ADC_CHANEL); g++) begin : g_flat
    assign baseline_rib_data[g*DATAWIDTH +: DATAWIDTH] = base_q[g];
    assign adc_noise[g*DATAWIDTH +: DATAWIDTH]         = noise_q[g];
    assign cal_adc_value[g*DATAWIDTH +: DATAWIDTH]     = cal_q[g];
    assign adc_test[g*DATAWIDTH +: DATAWIDTH]          = test_q[g];
  end

  assign rib_data_o        = rdata_q;
  assign rib_ack           = ack_q;
  assign data_accepted_rib = accepted_q;
  assign cfg_tx_data_num   = tx_data_num_q;
  assign cfg_udp_tx_enable = udp_tx_enable_q;
  assign cfg_fifo_wr_en    = fifo_wr_en_q;
  assign cfg_board_ip      = board_ip_q;
  assign cfg_des_ip        = des_ip_q;
  assign cfg_board_port    = board_port_q;
  assign cfg_des_port      = des_port_q;
  assign cfg_adc_width     = adc_width_q;
  assign cfg_datawidth     = datawidth_q;
  assign cfg_num_channels  = num_channels_q;
  assign cfg_fee_mode      = fee_mode_q;
  assign sys_status        = sys_status_q;

endmodule
